// File: rtl/alu_iterative_if.sv
// alu_iterative operand/result bus.
// Master drives the operation request, slave returns status and result.
interface alu_iterative_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [4:0]       FunSel;
  logic [SHW-1:0]   ShAmt;
  logic             WF;
  logic             Start;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] ALUOut;
  logic [3:0]       FlagsOut;

  modport master (
    output A, B, FunSel, ShAmt, WF, Start,
    input  Busy, Done, ALUOut, FlagsOut
  );

  modport slave (
    input  A, B, FunSel, ShAmt, WF, Start,
    output Busy, Done, ALUOut, FlagsOut
  );
endinterface

// File: rtl/alu_iterative.sv
// Registered ALU, full/half width, shifts/rotates one bit per cycle.
// FlagsOut is the {Z,C,N,O} architectural flag register.
module alu_iterative #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH) + 1
) (
  input logic            Clock,
  input logic            Reset,
  alu_iterative_if.slave bus
);
  localparam int H = WIDTH / 2;

  typedef enum logic {S_IDLE, S_EXEC} state_t;

  state_t           r_state, w_nxt;
  logic [WIDTH-1:0] r_a, r_b, r_work, r_out;
  logic [4:0]       r_fun;
  logic [SHW-1:0]   r_cnt;
  logic             r_wf, r_c, r_done;
  logic [3:0]       r_flags;

  logic             w_full, w_shift, w_accept, w_fin;
  logic             w_cy, w_ov, w_stc;
  logic [3:0]       w_op, w_flags;
  logic [WIDTH-1:0] w_mask, w_top, w_am, w_bm, w_wm;
  logic [WIDTH-1:0] w_res, w_step;
  logic [WIDTH:0]   w_sum;

  function automatic logic msb(
    input logic [WIDTH-1:0] x,
    input logic             full
  );
    return full ? x[WIDTH-1] : x[H-1];
  endfunction

  // operating-width masks and truncated operands
  always_comb begin
    w_full  = r_fun[4];
    w_op    = r_fun[3:0];
    w_shift = (w_op >= 4'hB);
    w_mask  = w_full ? {WIDTH{1'b1}}
                     : {{(WIDTH-H){1'b0}}, {H{1'b1}}};
    w_top   = w_full ? {1'b1, {(WIDTH-1){1'b0}}}
                     : {{(WIDTH-H){1'b0}}, 1'b1, {(H-1){1'b0}}};
    w_am    = r_a & w_mask;
    w_bm    = r_b & w_mask;
    w_wm    = r_work & w_mask;
  end

  // one bit step of the working register, carry as the extra bit
  always_comb begin
    w_step = w_wm;
    w_stc  = r_c;
    case (w_op)
      4'hB: begin
        w_stc  = msb(w_wm, w_full);
        w_step = (w_wm << 1) & w_mask;
      end
      4'hC: begin
        w_stc  = w_wm[0];
        w_step = w_wm >> 1;
      end
      4'hD: begin
        w_stc  = w_wm[0];
        w_step = (w_wm >> 1)
               | (msb(w_wm, w_full) ? w_top : '0);
      end
      4'hE: begin
        w_stc  = msb(w_wm, w_full);
        w_step = ((w_wm << 1) & w_mask)
               | {{(WIDTH-1){1'b0}}, r_c};
      end
      4'hF: begin
        w_stc  = w_wm[0];
        w_step = (w_wm >> 1) | (r_c ? w_top : '0);
      end
      default: ;
    endcase
  end

  // result, carry and overflow for the latched opcode
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_cy  = r_flags[2];
    w_ov  = r_flags[0];
    case (w_op)
      4'h0: w_res = w_am;
      4'h1: w_res = w_bm;
      4'h2: w_res = ~r_a & w_mask;
      4'h3: w_res = ~r_b & w_mask;
      4'h4, 4'h5, 4'h6: begin
        if (w_op == 4'h6)
          w_sum = {1'b0, w_am} + {1'b0, ~r_b & w_mask}
                + (WIDTH+1)'(1);
        else
          w_sum = {1'b0, w_am} + {1'b0, w_bm}
                + {{WIDTH{1'b0}}, (w_op == 4'h5) & r_c};
        w_res = w_sum[WIDTH-1:0] & w_mask;
        w_cy  = w_full ? w_sum[WIDTH] : w_sum[H];
        if (w_op == 4'h6)
          w_ov = (msb(w_am, w_full) != msb(w_bm, w_full))
               & (msb(w_res, w_full) != msb(w_am, w_full));
        else
          w_ov = (msb(w_am, w_full) == msb(w_bm, w_full))
               & (msb(w_res, w_full) != msb(w_am, w_full));
      end
      4'h7: w_res = w_am & w_bm;
      4'h8: w_res = w_am | w_bm;
      4'h9: w_res = w_am ^ w_bm;
      4'hA: w_res = ~(w_am & w_bm) & w_mask;
      default: begin
        w_res = (r_cnt == '0) ? w_wm : w_step;
        w_cy  = (r_cnt == '0) ? r_c : w_stc;
      end
    endcase
  end

  // flag vector written at completion
  always_comb begin
    w_flags[3] = (w_res == '0);
    w_flags[2] = w_cy;
    w_flags[1] = (w_op == 4'hC) ? 1'b0
               : (w_op == 4'hE) ? r_flags[1]
               : msb(w_res, w_full);
    w_flags[0] = w_ov;
  end

  // next state: accept in IDLE, leave EXEC on the last step
  always_comb begin
    w_nxt    = r_state;
    w_accept = 1'b0;
    w_fin    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.Start) begin
          w_accept = 1'b1;
          w_nxt    = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!w_shift || r_cnt <= SHW'(1)) begin
          w_fin = 1'b1;
          w_nxt = S_IDLE;
        end
      end
      default: w_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_nxt;
  end

  // operand latch, shift iteration and write-back
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_fun   <= '0;
      r_cnt   <= '0;
      r_wf    <= 1'b0;
      r_c     <= 1'b0;
      r_out   <= '0;
      r_flags <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_accept) begin
        r_a    <= bus.A;
        r_b    <= bus.B;
        r_work <= bus.A;
        r_fun  <= bus.FunSel;
        r_cnt  <= bus.ShAmt;
        r_wf   <= bus.WF;
        r_c    <= r_flags[2];
      end else if (r_state == S_EXEC && !w_fin) begin
        r_work <= w_step;
        r_c    <= w_stc;
        r_cnt  <= r_cnt - SHW'(1);
      end
      if (w_fin) begin
        r_out <= w_res;
        if (r_wf) r_flags <= w_flags;
      end
    end
  end

  assign bus.Busy     = (r_state == S_EXEC);
  assign bus.Done     = r_done;
  assign bus.ALUOut   = r_out;
  assign bus.FlagsOut = r_flags;
endmodule

// File: tb/tb_alu_iterative.sv
// Testbench for alu_iterative: directed table, corner sequences,
// randomized ops against an arithmetic reference model.
module tb_alu_iterative;
  logic Clock;
  logic Reset;
  int   n_vec = 0;
  int   n_err = 0;

  alu_iterative_if #(.WIDTH(16)) bus ();

  alu_iterative #(.WIDTH(16)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [4:0]  fun;
    logic [4:0]  sh;
    logic        wf;
    logic [15:0] eo;
    logic [3:0]  ef;
    int          lat;
  } vec_t;

  vec_t tbl[18];

  logic [15:0] mout;
  logic [3:0]  mflags;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic bit sgn(input longint v, input int w);
    return ((v >> (w - 1)) & 1) != 0;
  endfunction

  // reference: closed-form arithmetic on plain integers
  function automatic void model(
    input  logic [15:0] ia, ib,
    input  logic [4:0]  fun,
    input  int          sh,
    input  logic        wf,
    input  logic [3:0]  fin,
    output logic [15:0] res,
    output logic [3:0]  fo,
    output int          lat
  );
    int     w, op, k;
    longint mask, a, b, s, r, sa, x, lm;
    bit     z, c, n, o;
    w    = fun[4] ? 16 : 8;
    mask = (longint'(1) << w) - 1;
    a    = longint'(ia) & mask;
    b    = longint'(ib) & mask;
    op   = int'(fun[3:0]);
    c    = fin[2];
    o    = fin[0];
    r    = 0;
    case (op)
      0: r = a;
      1: r = b;
      2: r = ~a & mask;
      3: r = ~b & mask;
      4, 5, 6: begin
        if (op == 6) s = a + (~b & mask) + 1;
        else s = a + b + ((op == 5 && fin[2]) ? 1 : 0);
        r = s & mask;
        c = ((s >> w) & 1) != 0;
        if (op == 6)
          o = (sgn(a, w) != sgn(b, w)) && (sgn(r, w) != sgn(a, w));
        else
          o = (sgn(a, w) == sgn(b, w)) && (sgn(r, w) != sgn(a, w));
      end
      7:  r = a & b;
      8:  r = a | b;
      9:  r = a ^ b;
      10: r = ~(a & b) & mask;
      default: begin
        if (sh == 0) r = a;
        else begin
          case (op)
            11: begin
              r = (a << sh) & mask;
              c = (((a << sh) >> w) & 1) != 0;
            end
            12: begin
              r = a >> sh;
              c = ((a >> (sh - 1)) & 1) != 0;
            end
            13: begin
              sa = sgn(a, w) ? a - (longint'(1) << w) : a;
              r  = (sa >>> sh) & mask;
              c  = ((sa >>> (sh - 1)) & 1) != 0;
            end
            default: begin
              x  = (longint'(c) << w) | a;
              lm = (longint'(1) << (w + 1)) - 1;
              k  = sh % (w + 1);
              if (op == 14) x = ((x << k) | (x >> (w + 1 - k))) & lm;
              else          x = ((x >> k) | (x << (w + 1 - k))) & lm;
              c = ((x >> w) & 1) != 0;
              r = x & mask;
            end
          endcase
        end
      end
    endcase
    z = (r == 0);
    n = sgn(r, w);
    if (op == 12) n = 1'b0;
    if (op == 14) n = fin[1];
    fo  = wf ? {z, c, n, o} : fin;
    res = r[15:0];
    lat = (op < 11 || sh == 0) ? 1 : sh;
  endfunction

  task automatic scramble();
    bus.A      = 16'($urandom);
    bus.B      = 16'($urandom);
    bus.FunSel = 5'($urandom);
    bus.ShAmt  = 5'($urandom);
    bus.WF     = 1'($urandom);
  endtask

  task automatic run_op(
    input  logic [15:0] a, b,
    input  logic [4:0]  fun,
    input  logic [4:0]  sh,
    input  logic        wf,
    input  bit          poke,
    output logic [15:0] o,
    output logic [3:0]  f,
    output int          lat,
    output bit          bok
  );
    bok = 1'b1;
    lat = 0;
    bus.A = a; bus.B = b; bus.FunSel = fun;
    bus.ShAmt = sh; bus.WF = wf; bus.Start = 1'b1;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    scramble();
    if (bus.Busy !== 1'b1 || bus.Done !== 1'b0) bok = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (poke && k == 1) bus.Start = 1'b1;
      @(posedge Clock); #1;
      bus.Start = 1'b0;
      if (bus.Done === 1'b1) begin
        lat = k;
        break;
      end
      if (bus.Busy !== 1'b1) bok = 1'b0;
    end
    if (lat > 0 && bus.Busy !== 1'b0) bok = 1'b0;
    o = bus.ALUOut;
    f = bus.FlagsOut;
  endtask

  task automatic do_op(input logic [15:0] a, b,
                       input logic [4:0] fun,
                       input logic [4:0] sh,
                       input logic wf, input bit poke,
                       input logic [15:0] eo,
                       input logic [3:0] ef, input int el,
                       input string tag);
    logic [15:0] ao;
    logic [3:0]  af;
    int          al;
    bit          bok;
    run_op(a, b, fun, sh, wf, poke, ao, af, al, bok);
    check({tag, " out"},   32'(ao), 32'(eo));
    check({tag, " flags"}, 32'(af), 32'(ef));
    check({tag, " lat"},   32'(al), 32'(el));
    check({tag, " busy"},  32'(bok), 32'd1);
    mout   = eo;
    mflags = ef;
  endtask

  task automatic model_op(input logic [15:0] a, b,
                          input logic [4:0] fun,
                          input logic [4:0] sh,
                          input logic wf, input bit poke,
                          input string tag);
    logic [15:0] eo;
    logic [3:0]  ef;
    int          el;
    model(a, b, fun, int'(sh), wf, mflags, eo, ef, el);
    do_op(a, b, fun, sh, wf, poke, eo, ef, el, tag);
  endtask

  initial begin
    bit done_seen;
    tbl[0]  = '{16'h7FFF, 16'h0001, 5'b10100, 5'd0,  1'b1, 16'h8000, 4'b0011, 1};
    tbl[1]  = '{16'h0012, 16'h0034, 5'b00110, 5'd0,  1'b1, 16'h00DE, 4'b0010, 1};
    tbl[2]  = '{16'h0055, 16'h0055, 5'b00110, 5'd0,  1'b0, 16'h0000, 4'b0010, 1};
    tbl[3]  = '{16'h8001, 16'h0000, 5'b11101, 5'd3,  1'b1, 16'hF000, 4'b0010, 3};
    tbl[4]  = '{16'h8001, 16'h0000, 5'b11101, 5'd0,  1'b1, 16'h8001, 4'b0010, 1};
    tbl[5]  = '{16'h00FF, 16'h0001, 5'b00100, 5'd0,  1'b1, 16'h0000, 4'b1100, 1};
    tbl[6]  = '{16'h0080, 16'h0000, 5'b01110, 5'd1,  1'b1, 16'h0001, 4'b0100, 1};
    tbl[7]  = '{16'h00FF, 16'h0000, 5'b00101, 5'd0,  1'b1, 16'h0000, 4'b1100, 1};
    tbl[8]  = '{16'hF0F0, 16'hFF00, 5'b10111, 5'd0,  1'b1, 16'hF000, 4'b0110, 1};
    tbl[9]  = '{16'h1234, 16'h0000, 5'b01000, 5'd0,  1'b1, 16'h0034, 4'b0100, 1};
    tbl[10] = '{16'h8000, 16'h0000, 5'b11100, 5'd16, 1'b1, 16'h0000, 4'b1100, 16};
    tbl[11] = '{16'h0001, 16'h0000, 5'b11111, 5'd1,  1'b1, 16'h8000, 4'b0110, 1};
    tbl[12] = '{16'h8000, 16'h0001, 5'b10110, 5'd0,  1'b1, 16'h7FFF, 4'b0101, 1};
    tbl[13] = '{16'hFFFF, 16'hFFFF, 5'b11010, 5'd0,  1'b1, 16'h0000, 4'b1101, 1};
    tbl[14] = '{16'h00FF, 16'h0000, 5'b01011, 5'd9,  1'b1, 16'h0000, 4'b1001, 9};
    tbl[15] = '{16'h1234, 16'h0000, 5'b11110, 5'd17, 1'b1, 16'h1234, 4'b0001, 17};
    tbl[16] = '{16'h0000, 16'hABCD, 5'b00001, 5'd0,  1'b1, 16'h00CD, 4'b0011, 1};
    tbl[17] = '{16'h00FF, 16'h0000, 5'b10010, 5'd0,  1'b1, 16'hFF00, 4'b0011, 1};

    Reset = 1'b1;
    scramble();
    bus.Start = 1'b1;
    #2 Reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("rst ALUOut", 32'(bus.ALUOut),   32'h0);
    check("rst Flags",  32'(bus.FlagsOut), 32'h0);
    check("rst Busy",   32'(bus.Busy),     32'h0);
    check("rst Done",   32'(bus.Done),     32'h0);
    bus.Start = 1'b0;
    Reset = 1'b1;
    repeat (3) @(posedge Clock);
    #1;
    check("idle hold", 32'({bus.Busy, bus.Done, bus.FlagsOut, bus.ALUOut}), 32'h0);
    mout = '0;
    mflags = '0;

    for (int i = 0; i < 18; i++)
      do_op(tbl[i].a, tbl[i].b, tbl[i].fun, tbl[i].sh, tbl[i].wf,
            1'b1, tbl[i].eo, tbl[i].ef, tbl[i].lat, $sformatf("tbl%0d", i));

    bus.A = 16'h0F0F; bus.B = 16'h0; bus.FunSel = 5'b11011;
    bus.ShAmt = 5'd7; bus.WF = 1'b1; bus.Start = 1'b1;
    @(posedge Clock); #1;
    bus.Start = 1'b0;
    repeat (2) @(posedge Clock);
    #1;
    check("abort busy", 32'(bus.Busy), 32'h1);
    Reset = 1'b0;
    #1;
    check("abort out",   32'(bus.ALUOut),   32'h0);
    check("abort flags", 32'(bus.FlagsOut), 32'h0);
    check("abort state", 32'({bus.Busy, bus.Done}), 32'h0);
    @(posedge Clock); #1;
    Reset = 1'b1;
    done_seen = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge Clock); #1;
      if (bus.Done !== 1'b0 || bus.Busy !== 1'b0) done_seen = 1'b1;
    end
    check("abort no done", 32'(done_seen), 32'h0);
    mout = '0;
    mflags = '0;
    model_op(16'h0F0F, 16'h0, 5'b11011, 5'd7, 1'b1, 1'b0, "after abort");

    for (int i = 0; i < 300; i++) begin
      model_op(16'($urandom), 16'($urandom), 5'($urandom),
               5'($urandom_range(0, 20)), 1'($urandom),
               1'($urandom), $sformatf("rnd%0d", i));
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge Clock);
        #1;
        check($sformatf("rnd%0d hold", i),
              32'({bus.Busy, bus.Done, bus.FlagsOut, bus.ALUOut}),
              32'({2'b00, mflags, mout}));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
